// File: rtl/shift_sequencer.sv
// Command-driven shift sequencer: runs count shift cycles per accepted command through an external combinational shifter.
// Optional sticky left-shift overflow flag is built only when SHIFT_OVF_DETECT_EN is defined.
module shift_sequencer #(
  parameter int SIZE  = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIZE-1:0]  init_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_last,
  output logic [SIZE-1:0]  sh_data,
  output logic [1:0]       sh_coef,
  input  logic [SIZE-1:0]  sh_result,
  output logic [SIZE-1:0]  result,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [SIZE-1:0]  work;
  logic [CNT_W-1:0] rem;
  logic [1:0]       op_q;
  logic             last_q;
  logic             err_q;
  logic             accept;
  logic             cmd_bad;

  assign accept  = cmd_valid && (state == WAIT);
  assign cmd_bad = (cmd_op == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = WAIT;
      WAIT: begin
        if (accept) begin
          if (cmd_bad || (cmd_count == '0)) state_nxt = cmd_last ? DONE : WAIT;
          else                             state_nxt = SHIFT;
        end
      end
      SHIFT: if (rem == CNT_W'(1)) state_nxt = last_q ? DONE : WAIT;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An invalid op is never latched, so sh_coef keeps the last legal coefficient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      rem    <= '0;
      op_q   <= 2'b00;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if ((state == IDLE) && start) work <= init_data;
      if (accept) begin
        rem    <= cmd_count;
        last_q <= cmd_last;
        if (cmd_bad) err_q <= 1'b1;
        else         op_q  <= cmd_op;
      end
      if (state == SHIFT) begin
        work <= sh_result;
        rem  <= rem - CNT_W'(1);
      end
    end
  end

`ifdef SHIFT_OVF_DETECT_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      ovf_q <= 1'b0;
    end else if (state == SHIFT) begin
      if ((op_q == 2'b00) && work[SIZE-1])                 ovf_q <= 1'b1;
      if ((op_q == 2'b01) && (work[SIZE-1 -: 2] != 2'b00)) ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign cmd_ready = (state == WAIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = err_q;
  assign sh_data   = work;
  assign sh_coef   = op_q;
  assign result    = work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shifter model; inputs driven on negedge, outputs sampled on negedge.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] init_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic       cmd_last;
  logic [4:0] sh_data;
  logic [1:0] sh_coef;
  logic [4:0] sh_result;
  logic [4:0] result;
  logic       done, busy, err, ovf;

  int checks = 0;
  int errors = 0;
  int shifts;
  logic exp_ovf2;

  always #5 clk = ~clk;

  always_comb begin
    case (sh_coef)
      2'b00:   sh_result = {sh_data[3:0], 1'b0};
      2'b01:   sh_result = {sh_data[2:0], 2'b00};
      2'b10:   sh_result = {1'b0, sh_data[4:1]};
      default: sh_result = sh_data;
    endcase
  end

  shift_sequencer #(.SIZE(5), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_data(init_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .cmd_last(cmd_last), .sh_data(sh_data),
    .sh_coef(sh_coef), .sh_result(sh_result), .result(result),
    .done(done), .busy(busy), .err(err), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge where the FSM sits in WAIT.
  task automatic do_start(input logic [4:0] init);
    start     = 1'b1;
    init_data = init;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Called at a negedge in WAIT; returns at the first negedge outside SHIFT, with the SHIFT cycle count.
  task automatic send_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic last, output int n);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_last  = last;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!(busy && !cmd_ready && !done)) break;
      n++;
      @(negedge clk);
    end
  endtask

  // Called at the negedge showing DONE: done must drop after one cycle and the FSM go idle.
  task automatic finish_job(input string tag, input logic [4:0] exp_res);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
`ifdef SHIFT_OVF_DETECT_EN
    exp_ovf2 = 1'b1;
`else
    exp_ovf2 = 1'b0;
`endif
    rst_n = 1'b0; start = 1'b0; init_data = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0; cmd_last = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_result", 32'(result), 0);
    check("rst_coef", 32'(sh_coef), 0);
    check("rst_err_ovf_done", {29'd0, err, ovf, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Left by 1, twice.
    do_start(5'b00011);
    check("t1_ready", 32'(cmd_ready), 1);
    check("t1_load", 32'(result), 'b00011);
    send_cmd(2'b00, 3'd2, 1'b1, shifts);
    check("t1_shifts", shifts, 2);
    check("t1_ovf", 32'(ovf), 0);
    finish_job("t1", 5'b01100);

    // Left by 2 discarding a 1.
    do_start(5'b10110);
    send_cmd(2'b01, 3'd1, 1'b1, shifts);
    check("t2_shifts", shifts, 1);
    check("t2_ovf", 32'(ovf), 32'(exp_ovf2));
    finish_job("t2", 5'b11000);

    // Right by 1, three times.
    do_start(5'b11111);
    check("t3_ovf_cleared", 32'(ovf), 0);
    send_cmd(2'b10, 3'd3, 1'b1, shifts);
    check("t3_shifts", shifts, 3);
    check("t3_ovf", 32'(ovf), 0);
    finish_job("t3", 5'b00011);

    // Invalid op then a zero-count terminating no-op.
    do_start(5'b00101);
    send_cmd(2'b11, 3'd2, 1'b0, shifts);
    check("t4_shifts", shifts, 0);
    check("t4_err", 32'(err), 1);
    check("t4_work", 32'(result), 'b00101);
    check("t4_wait", 32'(cmd_ready), 1);
    check("t4_coef_kept", 32'(sh_coef), 'b10);
    send_cmd(2'b00, 3'd0, 1'b0 | 1'b1, shifts);
    check("t4_err_drop", 32'(err), 0);
    check("t4_noop_shifts", shifts, 0);
    finish_job("t4", 5'b00101);

    // Two commands in one job, with a stray start in WAIT.
    do_start(5'b00101);
    send_cmd(2'b00, 3'd1, 1'b0, shifts);
    check("t5_shifts_a", shifts, 1);
    check("t5_mid", 32'(result), 'b01010);
    check("t5_wait", 32'(cmd_ready), 1);
    start = 1'b1; init_data = 5'b11111;
    @(negedge clk);
    start = 1'b0;
    check("t5_start_ignored", 32'(result), 'b01010);
    check("t5_still_wait", 32'(cmd_ready), 1);
    send_cmd(2'b10, 3'd1, 1'b1, shifts);
    check("t5_shifts_b", shifts, 1);
    finish_job("t5", 5'b00101);

    // Asynchronous reset in the middle of SHIFT.
    do_start(5'b00001);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 3'd3; cmd_last = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t6_in_shift", 32'(sh_coef), 'b01);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_result", 32'(result), 0);
    check("t6_rst_data", 32'(sh_data), 0);
    check("t6_rst_coef", 32'(sh_coef), 0);
    check("t6_rst_flags", {28'd0, err, ovf, done, cmd_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(5'b00011);
    send_cmd(2'b00, 3'd2, 1'b1, shifts);
    check("t6_rerun_shifts", shifts, 2);
    finish_job("t6", 5'b01100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
